btb_fetch_pc: RTL

//  Fetch-stage next-PC generator, directly upstream of the branch target buffer. Holds the fetch PC,

---
 rtl/btb_fetch_pc_pkg.sv | 20 ++
 rtl/btb_update_reg.sv | 39 +++
 rtl/btb_fetch_pc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/btb_fetch_pc_pkg.sv
// btb_fetch_pc_pkg
//  Shared types and constants for the fetch-PC generator and its BTB write path.
//  Contents: rv32i_word address type, RESET_PC, fetch_state_t, btb_update_t.
package btb_fetch_pc_pkg;

   typedef logic [31:0] rv32i_word;

   localparam rv32i_word RESET_PC = 32'h0000_0060;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } fetch_state_t;

   typedef struct packed {
      rv32i_word pc;
      rv32i_word target;
   } btb_update_t;

endpackage

// File: rtl/btb_update_reg.sv
// btb_update_reg
//  Registers taken branch resolutions from EX and presents them to the BTB write
//  port one cycle later. Not-taken resolutions never write; the write address and
//  data hold their last value when no write is issued. Independent of fetch stall.
//  Ports:
//   clk, rst      clock, async active-high reset
//   ex_br_valid   EX resolved a control-flow instruction
//   ex_br_taken   resolved direction
//   ex_br_pc      branch PC
//   ex_br_target  resolved target
//   btb_load      BTB write enable (registered)
//   upd           registered {pc, target} for the BTB write port
module btb_update_reg
   import btb_fetch_pc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_br_valid,
   input  logic        ex_br_taken,
   input  rv32i_word   ex_br_pc,
   input  rv32i_word   ex_br_target,
   output logic        btb_load,
   output btb_update_t upd
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btb_load <= 1'b0;
         upd      <= '0;
      end else begin
         btb_load <= ex_br_valid & ex_br_taken;
         if (ex_br_valid & ex_br_taken) begin
            upd.pc     <= ex_br_pc;
            upd.target <= ex_br_target;
         end
      end
   end

endmodule

// File: rtl/btb_fetch_pc.sv
// btb_fetch_pc
//  Fetch-stage next-PC generator sitting in front of the BTB. Holds the fetch PC,
//  drives the BTB read port and instruction-memory address, selects the next PC
//  (redirect > pending redirect > BTB prediction > pc+4) and registers
//  {pc, prediction} into IF/ID. Also forwards resolved-taken branches to the
//  BTB write port through btb_update_reg.
//  Ports:
//   clk, rst                       clock, async active-high reset
//   stall                          freeze fetch; pc and IF/ID hold
//   redirect, redirect_pc          EX flush and corrected next PC
//   btb_hit, btb_target            same-cycle BTB lookup result for btb_r_pc
//   btb_r_pc, imem_address         current fetch PC
//   imem_read                      fetch request (high from first edge after reset)
//   id_valid, id_pc                IF/ID entry
//   id_pred_taken, id_pred_target  prediction carried with id_pc
//   ex_br_*                        EX branch resolution
//   btb_w_pc, btb_load, btb_target_in  BTB write port
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  RUN   | normal fetch; pc advances each unstalled cycle
//  PEND  | redirect arrived under stall; current fetch is wrong-path,
//        | pend_pc holds newest redirect target until stall drops
module btb_fetch_pc
   import btb_fetch_pc_pkg::*;
#(
   parameter int               width    = 32,
   parameter logic [width-1:0] reset_pc = RESET_PC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [width-1:0] redirect_pc,
   input  logic             btb_hit,
   input  logic [width-1:0] btb_target,
   output logic [width-1:0] btb_r_pc,
   output logic [width-1:0] imem_address,
   output logic             imem_read,
   output logic             id_valid,
   output logic [width-1:0] id_pc,
   output logic             id_pred_taken,
   output logic [width-1:0] id_pred_target,
   input  logic             ex_br_valid,
   input  logic             ex_br_taken,
   input  logic [width-1:0] ex_br_pc,
   input  logic [width-1:0] ex_br_target,
   output logic [width-1:0] btb_w_pc,
   output logic             btb_load,
   output logic [width-1:0] btb_target_in
);

   fetch_state_t     state;
   logic [width-1:0] pc;
   logic [width-1:0] pend_pc;
   logic [width-1:0] redirect_al;
   logic [width-1:0] target_al;
   logic             unused_low_bits;
   btb_update_t      upd;

   // Instructions are word aligned: low two address bits are dropped on entry.
   assign redirect_al     = {redirect_pc[width-1:2], 2'b00};
   assign target_al       = {btb_target[width-1:2], 2'b00};
   assign unused_low_bits = ^{redirect_pc[1:0], btb_target[1:0]};

   assign btb_r_pc     = pc;
   assign imem_address = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RUN;
         pc             <= reset_pc;
         pend_pc        <= '0;
         imem_read      <= 1'b0;
         id_valid       <= 1'b0;
         id_pc          <= '0;
         id_pred_taken  <= 1'b0;
         id_pred_target <= '0;
      end else begin
         imem_read <= 1'b1;
         case (state)
            RUN: begin
               if (redirect) begin
                  if (stall) begin
                     pend_pc <= redirect_al;
                     state   <= PEND;
                  end else begin
                     pc       <= redirect_al;
                     id_valid <= 1'b0;
                  end
               end else if (!stall) begin
                  pc             <= btb_hit ? target_al : pc + width'(4);
                  id_valid       <= 1'b1;
                  id_pc          <= pc;
                  id_pred_taken  <= btb_hit;
                  id_pred_target <= btb_hit ? target_al : '0;
               end
            end
            PEND: begin
               if (redirect)
                  pend_pc <= redirect_al;
               // A redirect on the exit cycle is newer than pend_pc.
               if (!stall) begin
                  pc       <= redirect ? redirect_al : pend_pc;
                  id_valid <= 1'b0;
                  state    <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   btb_update_reg u_update (
      .clk          (clk),
      .rst          (rst),
      .ex_br_valid  (ex_br_valid),
      .ex_br_taken  (ex_br_taken),
      .ex_br_pc     (ex_br_pc),
      .ex_br_target (ex_br_target),
      .btb_load     (btb_load),
      .upd          (upd)
   );

   assign btb_w_pc      = upd.pc;
   assign btb_target_in = upd.target;

endmodule
